// File: rtl/decode_execute_buffer.sv
// decode_execute_buffer: two-entry skid buffer feeding the ALU execute stage, with writeback capture and flush
module decode_execute_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALUOP_WIDTH    = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      dec_valid_i,
  output logic                      dec_ready_o,
  input  logic [DATA_WIDTH-1:0]     dec_operand1_i,
  input  logic [DATA_WIDTH-1:0]     dec_operand2_i,
  input  logic [ALUOP_WIDTH-1:0]    dec_aluop_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_i,
  input  logic                      dec_use_rs1_i,
  input  logic                      dec_use_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rd_i,
  input  logic                      dec_we_i,
  input  logic                      wb_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output logic [DATA_WIDTH-1:0]     ex_operand1_o,
  output logic [DATA_WIDTH-1:0]     ex_operand2_o,
  output logic [ALUOP_WIDTH-1:0]    ex_aluop_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_o,
  output logic                      ex_we_o
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     op1;
    logic [DATA_WIDTH-1:0]     op2;
    logic [ALUOP_WIDTH-1:0]    aluop;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      use1;
    logic                      use2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      we;
  } entry_t;
  // Refresh an entry's register-sourced operands from the writeback port; r0 and immediates never change.
  function automatic entry_t f_cap(entry_t e, logic we, logic [REG_ADDR_WIDTH-1:0] rd, logic [DATA_WIDTH-1:0] d);
    f_cap = e;
    if (we && rd != '0 && rd == e.rs1 && e.use1) f_cap.op1 = d;
    if (we && rd != '0 && rd == e.rs2 && e.use2) f_cap.op2 = d;
  endfunction
  state_t r_state, w_state_nxt;
  entry_t r_out, r_skid, w_out_nxt, w_skid_nxt, w_in, w_in_c, w_out_c, w_skid_c;
  logic   r_dec_ready;
  logic   w_accept, w_pop;
  assign w_in = {dec_operand1_i, dec_operand2_i, dec_aluop_i, dec_rs1_i, dec_rs2_i,
                 dec_use_rs1_i, dec_use_rs2_i, dec_rd_i, dec_we_i};
  assign w_in_c   = f_cap(w_in, wb_we_i, wb_rd_i, wb_data_i);
  assign w_out_c  = f_cap(r_out, wb_we_i, wb_rd_i, wb_data_i);
  assign w_skid_c = f_cap(r_skid, wb_we_i, wb_rd_i, wb_data_i);
  assign w_accept = dec_valid_i && r_dec_ready;
  assign w_pop    = ex_valid_o && ex_ready_i;
  // Occupancy transitions and data steering; captured values win over moved or loaded ones.
  always_comb begin
    w_state_nxt = flush_i ? EMPTY :
                  r_state == EMPTY ? (w_accept ? ONE : EMPTY) :
                  r_state == ONE   ? (w_accept && !w_pop ? FULL : (w_pop && !w_accept ? EMPTY : ONE)) :
                                     (w_pop ? ONE : FULL);
    w_out_nxt   = (r_state == FULL && w_pop) ? w_skid_c :
                  (w_accept && (r_state == EMPTY || w_pop)) ? w_in_c : w_out_c;
    w_skid_nxt  = (w_accept && r_state == ONE && !w_pop) ? w_in_c : w_skid_c;
  end
  // State, ready flag and entry registers; ready is registered from the next occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= EMPTY;
      r_dec_ready <= 1'b1;
      r_out       <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dec_ready <= w_state_nxt != FULL;
      r_out       <= w_out_nxt;
      r_skid      <= w_skid_nxt;
    end
  end
  assign dec_ready_o   = r_dec_ready;
  assign ex_valid_o    = r_state != EMPTY;
  assign ex_operand1_o = r_out.op1;
  assign ex_operand2_o = r_out.op2;
  assign ex_aluop_o    = r_out.aluop;
  assign ex_rd_o       = r_out.rd;
  assign ex_we_o       = r_out.we;
endmodule

// File: tb/tb_decode_execute_buffer.sv
// tb_decode_execute_buffer: directed plan scenarios plus random traffic checked against a queue model
module tb_decode_execute_buffer;
  logic        clk = 0, rst, flush, dec_valid, dec_ready, dec_u1, dec_u2, dec_we;
  logic [31:0] dec_op1, dec_op2, wb_data, ex_op1, ex_op2;
  logic [3:0]  dec_aluop, ex_aluop;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd, ex_rd;
  logic        wb_we, ex_valid, ex_ready, ex_we;
  typedef struct packed {
    logic [31:0] op1, op2;
    logic [3:0]  aluop;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        we;
  } op_t;
  op_t q[$];
  bit  zero_fields;
  int  n_chk = 0, n_fail = 0;

  decode_execute_buffer dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
    .dec_operand1_i(dec_op1), .dec_operand2_i(dec_op2), .dec_aluop_i(dec_aluop),
    .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2), .dec_use_rs1_i(dec_u1), .dec_use_rs2_i(dec_u2),
    .dec_rd_i(dec_rd), .dec_we_i(dec_we),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_operand1_o(ex_op1), .ex_operand2_o(ex_op2), .ex_aluop_o(ex_aluop),
    .ex_rd_o(ex_rd), .ex_we_o(ex_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic op_t cap(op_t e);
    cap = e;
    if (wb_we && wb_rd != 0 && wb_rd == e.rs1 && e.u1) cap.op1 = wb_data;
    if (wb_we && wb_rd != 0 && wb_rd == e.rs2 && e.u2) cap.op2 = wb_data;
  endfunction

  task automatic check_outputs();
    chk("ex_valid", ex_valid, q.size() > 0);
    chk("dec_ready", dec_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("ex_operand1", ex_op1, q[0].op1);
      chk("ex_operand2", ex_op2, q[0].op2);
      chk("ex_ctrl", {ex_aluop, ex_rd, ex_we}, {q[0].aluop, q[0].rd, q[0].we});
    end else if (zero_fields) begin
      chk("reset_operands", {ex_op1, ex_op2}, 64'd0);
      chk("reset_ctrl", {ex_aluop, ex_rd, ex_we}, 0);
    end
  endtask

  task automatic model_update();
    bit acc, pop;
    acc = dec_valid && q.size() < 2;
    pop = q.size() > 0 && ex_ready;
    if (rst) begin
      q.delete();
      zero_fields = 1;
    end else begin
      if (acc) zero_fields = 0;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        foreach (q[i]) q[i] = cap(q[i]);
        if (acc) q.push_back(cap({dec_op1, dec_op2, dec_aluop, dec_rs1, dec_rs2, dec_u1, dec_u2, dec_rd, dec_we}));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
    dec_valid = v; dec_op1 = a; dec_op2 = b; dec_aluop = op;
    dec_rs1 = r1; dec_rs2 = r2; dec_u1 = u1; dec_u2 = u2;
    dec_rd = 5'(op) + 5'd1; dec_we = op[0];
  endtask

  initial begin
    rst = 1; flush = 0; ex_ready = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    offer(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    step(); step();
    rst = 0;
    step();
    // streaming
    ex_ready = 1;
    for (int i = 0; i < 8; i++) begin
      offer(1, 32'h10 + i, i, 4'(i), 0, 0, 0, 0);
      step();
    end
    dec_valid = 0;
    step(); step();
    // backpressure A, B, C
    ex_ready = 0;
    offer(1, 32'hA, 1, 4'hA, 0, 0, 0, 0); step();
    offer(1, 32'hB, 2, 4'hB, 0, 0, 0, 0); step();
    offer(1, 32'hC, 3, 4'hC, 0, 0, 0, 0); step(); step();
    chk("bp_stall_ready", dec_ready, 0);
    ex_ready = 1;
    step(); dec_valid = 0; step(); step(); step(); step();
    // writeback into held entry
    ex_ready = 0;
    offer(1, 32'h1111, 32'h2222, 3, 5, 6, 1, 1); step();
    dec_valid = 0; wb_we = 1; wb_rd = 5; wb_data = 32'hDEAD; step();
    wb_we = 0;
    chk("wb_op1", ex_op1, 32'hDEAD);
    chk("wb_op2_kept", ex_op2, 32'h2222);
    flush = 1; step(); flush = 0;
    // r0 and immediate operands are never captured
    offer(1, 32'h3333, 32'h4444, 1, 0, 7, 1, 0);
    wb_we = 1; wb_rd = 0; wb_data = 32'hBEEF; step();
    dec_valid = 0; wb_rd = 7; step();
    chk("r0_excl", ex_op1, 32'h3333);
    chk("imm_excl", ex_op2, 32'h4444);
    flush = 1; wb_we = 0; step(); flush = 0;
    // capture on the accept cycle
    offer(1, 32'h1, 32'h2, 2, 9, 0, 1, 0);
    wb_we = 1; wb_rd = 9; wb_data = 32'hCAFE; step();
    dec_valid = 0; wb_we = 0;
    chk("accept_capture", ex_op1, 32'hCAFE);
    step();
    // flush while FULL together with an offered op
    ex_ready = 0;
    offer(1, 32'h51, 0, 5, 0, 0, 0, 0); step();
    offer(1, 32'h52, 0, 6, 0, 0, 0, 0); step();
    offer(1, 32'h53, 0, 7, 0, 0, 0, 0); flush = 1; step();
    flush = 0; dec_valid = 0;
    chk("flush_valid", ex_valid, 0);
    chk("flush_ready", dec_ready, 1);
    ex_ready = 1; step(); step();
    // reset while FULL
    ex_ready = 0;
    offer(1, 32'h61, 32'h7, 9, 0, 0, 0, 0); step();
    offer(1, 32'h62, 32'h8, 8, 0, 0, 0, 0); step();
    dec_valid = 0; rst = 1; step(); rst = 0;
    chk("rst_valid", ex_valid, 0);
    chk("rst_op1", ex_op1, 0);
    step();
    offer(1, 32'h71, 0, 4, 0, 0, 0, 0); step();
    dec_valid = 0;
    chk("post_rst_latency", ex_valid, 1);
    ex_ready = 1; step();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      offer($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      ex_ready = $urandom_range(0, 3) != 0;
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      flush = $urandom_range(0, 31) == 0;
      rst = $urandom_range(0, 127) == 0;
      step();
    end
    rst = 0; flush = 0; dec_valid = 0; wb_we = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
